// File: rtl/jk_latch_driver.sv
// Command sequencer for a JK latch stage. Each accepted command becomes a
// timed j/k/enable waveform (setup, pulse, hold). The latch q is then sampled
// and returned with a mismatch flag against the expected JK result.
module jk_latch_driver #(
    parameter int unsigned SETUP_CYC     = 1,
    parameter int unsigned PULSE_CYC     = 1,
    parameter int unsigned HOLD_CYC      = 1,
    // op_count value after reset; zero in normal use
    parameter logic [15:0] OP_COUNT_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_i,
    output logic        j_o,
    output logic        k_o,
    output logic        enable_o,
    input  logic        q_in_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_q_o,
    output logic        rsp_err_o,
    output logic [15:0] op_count_o
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OPC_W = 16;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [OPC_W-1:0] OPC_MAX  = {OPC_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        PULSE  = 3'd2,
        HOLD   = 3'd3,
        SAMPLE = 3'd4,
        RESP   = 3'd5
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cmd_ready_q;
    logic               j_q;
    logic               k_q;
    logic               enable_q;
    logic               rsp_valid_q;
    logic               rsp_q_q;
    logic               rsp_err_q;
    logic               last_q_q;
    logic               known_q;
    logic [OPC_W-1:0]   op_count_q;

    logic               expect_d;
    logic               defined_d;
    logic               err_d;

    // Expected latch output for the captured command and the resulting mismatch flag
    always_comb begin
        expect_d  = 1'b0;
        defined_d = 1'b1;
        unique case ({j_q, k_q})
            2'b01:   expect_d = 1'b0;
            2'b10:   expect_d = 1'b1;
            2'b00:   begin expect_d = last_q_q;  defined_d = known_q; end
            default: begin expect_d = ~last_q_q; defined_d = known_q; end
        endcase
        err_d = defined_d & (q_in_i ^ expect_d);
    end

    // Sequencer FSM with registered latch drives and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            last_q_q    <= 1'b0;
            known_q     <= 1'b0;
            op_count_q  <= OP_COUNT_INIT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        j_q         <= cmd_i[1];
                        k_q         <= cmd_i[0];
                        cnt_q       <= SETUP_LD;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        enable_q <= 1'b1;
                        cnt_q    <= PULSE_LD;
                        state_q  <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        enable_q <= 1'b0;
                        cnt_q    <= HOLD_LD;
                        state_q  <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    rsp_q_q     <= q_in_i;
                    rsp_err_q   <= err_d;
                    last_q_q    <= q_in_i;
                    known_q     <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    j_q         <= 1'b0;
                    k_q         <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                        if (op_count_q != OPC_MAX) begin
                            op_count_q <= op_count_q + OPC_W'(1);
                        end
                    end
                end
                default: begin
                    j_q         <= 1'b0;
                    k_q         <= 1'b0;
                    enable_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign j_o         = j_q;
    assign k_o         = k_q;
    assign enable_o    = enable_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_q_o     = rsp_q_q;
    assign rsp_err_o   = rsp_err_q;
    assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_jk_latch_driver.sv
// Bench for jk_latch_driver: two instances (default timing, and 3/2/4 timing
// with op_count starting near saturation), each driving a behavioural JK latch
// and checked every cycle against a timeline model of the command sequence.
module tb_jk_latch_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int unsigned S    = (g == 0) ? 1 : 3;
        localparam int unsigned P    = (g == 0) ? 1 : 2;
        localparam int unsigned H    = (g == 0) ? 1 : 4;
        localparam logic [15:0] INIT = (g == 0) ? 16'h0000 : 16'hFFFE;

        logic        rst_n     = 1'b0;
        logic        cmd_valid = 1'b0;
        logic [1:0]  cmd       = 2'b00;
        logic        rsp_ready = 1'b0;
        logic        cmd_ready, j, k, enable, q_in, rsp_valid, rsp_q, rsp_err;
        logic [15:0] op_count;
        logic        lq    = 1'b0;
        logic        stuck = 1'b0;

        assign q_in = stuck ? 1'b0 : lq;

        jk_latch_driver #(
            .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .OP_COUNT_INIT(INIT)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_i(cmd),
            .j_o(j), .k_o(k), .enable_o(enable), .q_in_i(q_in),
            .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
            .rsp_q_o(rsp_q), .rsp_err_o(rsp_err), .op_count_o(op_count)
        );

        // Behavioural JK latch: applies the j/k function once per enable pulse
        always @(posedge enable) begin
            case ({j, k})
                2'b01:   lq <= 1'b0;
                2'b10:   lq <= 1'b1;
                2'b11:   lq <= ~lq;
                default: lq <= lq;
            endcase
        end

        // Reference model: phase 0 idle, 1 in flight (timed from acceptance), 2 response
        int unsigned cyc;
        int unsigned t_acc;
        int          ph;
        logic [1:0]  mc;
        logic        m_last, m_known, m_q, m_err, m_e, m_def;
        logic [15:0] m_cnt;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ph = 0; cyc = 0; t_acc = 0; mc = 2'b00;
                m_last = 1'b0; m_known = 1'b0; m_q = 1'b0; m_err = 1'b0;
                m_cnt = INIT;
            end else begin
                cyc++;
                if (ph == 0) begin
                    if (cmd_valid) begin
                        ph = 1; t_acc = cyc; mc = cmd;
                    end
                end else if (ph == 1) begin
                    if (cyc == t_acc + S + P + H + 1) begin
                        m_def = m_known || (mc == 2'b01) || (mc == 2'b10);
                        m_e   = (mc == 2'b10) ? 1'b1 : (mc == 2'b01) ? 1'b0 :
                                (mc == 2'b00) ? m_last : ~m_last;
                        m_q     = q_in;
                        m_err   = m_def && (q_in != m_e);
                        m_last  = q_in;
                        m_known = 1'b1;
                        ph      = 2;
                    end
                end else if (rsp_ready) begin
                    ph = 0;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
        end

        // Per-cycle comparison of every output against the model
        int unsigned d_cyc;
        logic        busy;
        always @(negedge clk) begin
            if (rst_n) begin
                d_cyc = cyc - t_acc;
                busy  = (ph == 1);
                chk($sformatf("u%0d.cmd_ready", g), 32'(cmd_ready), 32'(ph == 0));
                chk($sformatf("u%0d.j", g), 32'(j), 32'(busy & mc[1]));
                chk($sformatf("u%0d.k", g), 32'(k), 32'(busy & mc[0]));
                chk($sformatf("u%0d.enable", g), 32'(enable),
                    32'(busy && d_cyc >= S && d_cyc < S + P));
                chk($sformatf("u%0d.rsp_valid", g), 32'(rsp_valid), 32'(ph == 2));
                chk($sformatf("u%0d.rsp_q", g), 32'(rsp_q), 32'(m_q));
                if (ph == 2) chk($sformatf("u%0d.rsp_err", g), 32'(rsp_err), 32'(m_err));
                chk($sformatf("u%0d.op_count", g), 32'(op_count), 32'(m_cnt));
            end
        end

        // Issue one command and time it; with bp set the response is left pending
        task automatic do_cmd(input logic [1:0] c, input bit bp,
                              output logic rq, output logic re, output int lat,
                              output int en_cyc, output int en_first, output int j_cyc);
            int  n;
            bit  ok;
            rsp_ready = !bp;
            ok = 1'b0;
            for (int w = 0; w < 100 && !ok; w++) begin
                @(negedge clk);
                ok = cmd_ready;
            end
            chk($sformatf("u%0d.idle_wait", g), 32'(ok), 32'd1);
            cmd = c; cmd_valid = 1'b1;
            @(posedge clk);
            n = 0; lat = -1; en_cyc = 0; en_first = -1; j_cyc = 0;
            while (n < 200 && lat < 0) begin
                @(negedge clk);
                if (n == 0) cmd_valid = 1'b0;
                cmd = 2'($urandom);
                if (enable) begin
                    en_cyc++;
                    if (en_first < 0) en_first = n;
                end
                if (j) j_cyc++;
                if (rsp_valid) lat = n;
                else @(posedge clk);
                n++;
            end
            chk($sformatf("u%0d.rsp_timeout", g), 32'(lat >= 0), 32'd1);
            rq = rsp_q; re = rsp_err;
            if (!bp) @(posedge clk);
        endtask

        task automatic rand_run(input int ncyc);
            for (int i = 0; i < ncyc; i++) begin
                @(negedge clk);
                cmd_valid = 1'($urandom);
                cmd       = 2'($urandom);
                rsp_ready = ($urandom_range(0, 3) != 0);
                stuck     = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            cmd_valid = 1'b0; rsp_ready = 1'b1; stuck = 1'b0;
        endtask
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        logic rq, re;
        int   lat, enc, enf, jc;
        bit   seen;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst.cmd_ready", 32'(u[0].cmd_ready), 32'd1);
        chk("rst.enable", 32'(u[0].enable), 32'd0);
        chk("rst.rsp_valid", 32'(u[0].rsp_valid), 32'd0);
        chk("rst.op_count", 32'(u[0].op_count), 32'd0);
        chk("rst.op_count_init", 32'(u[1].op_count), 32'hFFFE);
        u[0].rst_n = 1'b1; u[1].rst_n = 1'b1;

        // Asynchronous reset in the middle of the enable pulse
        @(negedge clk);
        u[0].cmd = 2'b10; u[0].cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u[0].cmd_valid = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            if (u[0].enable) seen = 1'b1;
            else @(negedge clk);
        end
        chk("midpulse.enable_seen", 32'(seen), 32'd1);
        #2 u[0].rst_n = 1'b0;
        #1;
        chk("midpulse.async_enable", 32'(u[0].enable), 32'd0);
        chk("midpulse.cmd_ready", 32'(u[0].cmd_ready), 32'd1);
        @(negedge clk);
        u[0].rst_n = 1'b1;
        u[0].do_cmd(2'b00, 1'b0, rq, re, lat, enc, enf, jc);
        chk("midpulse.hold_err", 32'(re), 32'd0);

        // Default timing against the latch, fresh op_count
        @(negedge clk) u[0].rst_n = 1'b0;
        @(negedge clk) u[0].rst_n = 1'b1;
        u[0].do_cmd(2'b10, 1'b0, rq, re, lat, enc, enf, jc);
        chk("def.set_q", 32'(rq), 32'd1);
        chk("def.set_err", 32'(re), 32'd0);
        chk("def.latency", 32'(lat), 32'd4);
        chk("def.en_cycles", 32'(enc), 32'd1);
        chk("def.en_first", 32'(enf), 32'd1);
        chk("def.j_cycles", 32'(jc), 32'd4);
        u[0].do_cmd(2'b01, 1'b0, rq, re, lat, enc, enf, jc);
        chk("def.reset_q", 32'(rq), 32'd0);
        chk("def.reset_err", 32'(re), 32'd0);
        u[0].do_cmd(2'b11, 1'b0, rq, re, lat, enc, enf, jc);
        chk("def.toggle_q", 32'(rq), 32'd1);
        chk("def.toggle_err", 32'(re), 32'd0);
        u[0].do_cmd(2'b00, 1'b0, rq, re, lat, enc, enf, jc);
        chk("def.hold_q", 32'(rq), 32'd1);
        chk("def.hold_err", 32'(re), 32'd0);
        @(negedge clk);
        chk("def.op_count", 32'(u[0].op_count), 32'd4);

        // Backpressure on the response
        u[0].do_cmd(2'b10, 1'b1, rq, re, lat, enc, enf, jc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.rsp_valid", 32'(u[0].rsp_valid), 32'd1);
            chk("bp.rsp_q", 32'(u[0].rsp_q), 32'd1);
            chk("bp.rsp_err", 32'(u[0].rsp_err), 32'd0);
            chk("bp.cmd_ready", 32'(u[0].cmd_ready), 32'd0);
            chk("bp.op_count", 32'(u[0].op_count), 32'd4);
        end
        u[0].rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp.op_count_after", 32'(u[0].op_count), 32'd5);
        chk("bp.cmd_ready_after", 32'(u[0].cmd_ready), 32'd1);

        // Latch output stuck at 0
        u[0].stuck = 1'b1;
        u[0].do_cmd(2'b10, 1'b0, rq, re, lat, enc, enf, jc);
        chk("fault.set_q", 32'(rq), 32'd0);
        chk("fault.set_err", 32'(re), 32'd1);
        u[0].do_cmd(2'b11, 1'b0, rq, re, lat, enc, enf, jc);
        chk("fault.toggle_q", 32'(rq), 32'd0);
        chk("fault.toggle_err", 32'(re), 32'd1);
        u[0].stuck = 1'b0;

        // Stretched timing and op_count saturation
        u[1].do_cmd(2'b10, 1'b0, rq, re, lat, enc, enf, jc);
        chk("cfg.latency", 32'(lat), 32'd10);
        chk("cfg.en_cycles", 32'(enc), 32'd2);
        chk("cfg.en_first", 32'(enf), 32'd3);
        chk("cfg.j_cycles", 32'(jc), 32'd10);
        chk("cfg.set_q", 32'(rq), 32'd1);
        @(negedge clk);
        chk("sat.first", 32'(u[1].op_count), 32'hFFFF);
        u[1].do_cmd(2'b01, 1'b0, rq, re, lat, enc, enf, jc);
        chk("cfg.reset_q", 32'(rq), 32'd0);
        @(negedge clk);
        chk("sat.second", 32'(u[1].op_count), 32'hFFFF);

        // Random traffic on both instances, checked by the per-cycle models
        fork
            u[0].rand_run(1500);
            u[1].rand_run(1500);
        join
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_latch_driver.md
# jk_latch_driver

Command sequencer that sits directly upstream of the JK latch stage: it accepts hold/reset/set/toggle commands over a valid/ready handshake and turns each one into a timed j/k/enable waveform with programmable setup, pulse and hold windows. After the hold window it samples the latch's q output and returns the value, plus a mismatch flag against the expected JK result, over a second valid/ready handshake. The block bounds the enable pulse to a known cycle count, which keeps toggle commands free of race-around, and gives the bench a scored, self-checking path into the latch.

## Interface
- SETUP_CYC, default 1: cycles j/k are stable before enable rises; legal range 1–255.
- PULSE_CYC, default 1: cycles enable is held high; legal range 1–255.
- HOLD_CYC, default 1: cycles j/k are held after enable falls; legal range 1–255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd  in  2  {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
- j  out  1  registered drive to the latch j input.
- k  out  1  registered drive to the latch k input.
- enable  out  1  registered drive to the latch enable input.
- q_in  in  1  latch q output, sampled in SAMPLE.
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_q  out  1  q value sampled for this command.
- rsp_err  out  1  rsp_q differs from the expected value; only meaningful while rsp_valid is high.
- op_count  out  16  number of completed responses; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE → SETUP → PULSE → HOLD → SAMPLE → RESP → IDLE.
- IDLE: cmd_ready=1, j=k=enable=0.
  - On cmd_valid && cmd_ready: load j,k from cmd, load the phase counter with SETUP_CYC−1, go to SETUP.
- SETUP: j/k driven and enable=0.
  - At counter 0: go to PULSE and load PULSE_CYC−1.
- PULSE: enable=1, j/k unchanged.
  - At counter 0: go to HOLD and load HOLD_CYC−1.
- HOLD: enable=0, j/k unchanged.
  - At counter 0: go to SAMPLE.
- SAMPLE (one cycle): enable=0, j/k unchanged.
  - Register q_in into rsp_q.
  - Compute rsp_err.
  - Update the tracked state: last_q ← q_in, known ← 1.
  - Go to RESP.
- RESP: rsp_valid=1, j=k=0, enable=0.
  - On rsp_ready: increment op_count (saturating) and return to IDLE.
- Expected value by command:
  - 01 → 0.
  - 10 → 1.
  - 00 → last_q.
  - 11 → ~last_q.
- When known=0 (first command after reset), 00 and 11 have no defined expectation and force rsp_err=0.
- cmd is captured only at acceptance; changes to cmd outside IDLE are ignored.

## Timing
- Reset values of all outputs: cmd_ready=1, j=0, k=0, enable=0, rsp_valid=0, rsp_q=0, rsp_err=0, op_count=0.
- Internal reset values: state=IDLE, last_q=0, known=0.
- Asserting rst_n low forces enable=0 immediately and asynchronously, from any state, including mid-PULSE.
- Let edge E be the edge that accepts a command:
  - j/k are valid from E.
  - enable is high from E+SETUP_CYC through E+SETUP_CYC+PULSE_CYC (high for exactly PULSE_CYC cycles).
  - q_in is sampled at edge E+SETUP_CYC+PULSE_CYC+HOLD_CYC+1.
  - rsp_valid rises at that same edge.
- Latency from acceptance to rsp_valid is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles; 4 cycles with defaults.
- Response handshake: a response transfers on a rising edge with rsp_valid && rsp_ready.
  - rsp_q and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- cmd_ready rises in the cycle after the response handshake; there is no command/response overlap.
- Minimum issue interval with rsp_ready tied high: SETUP+PULSE+HOLD+3 cycles; 6 with defaults.
- op_count updates on the handshake edge and stays at 16'hFFFF once reached.

## Test plan
- Reset mid-PULSE:
  - Assert rst_n=0 while enable=1 → enable=0 without waiting for a clock edge; state returns to IDLE.
  - Then issue hold (00) → rsp_err=0, because known=0.
- Defaults with a real JK latch, rsp_ready=1:
  - Issue 10 → rsp_q=1, rsp_err=0, rsp_valid 4 cycles after acceptance, enable high for exactly 1 cycle.
  - Issue 01 → rsp_q=0.
  - Issue 11 → rsp_q=1.
  - Issue 00 → rsp_q=1.
  - All four report rsp_err=0; op_count=4.
- SETUP_CYC=3, PULSE_CYC=2, HOLD_CYC=4:
  - j/k change 3 cycles before enable rises; enable high for exactly 2 cycles; j/k stable for 4 cycles after enable falls.
  - rsp_valid rises 10 cycles after acceptance.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after a set command → rsp_valid, rsp_q=1 and rsp_err stay stable; cmd_ready=0; op_count unchanged.
  - Release rsp_ready → op_count increments by 1 and cmd_ready=1 on the next cycle.
- Fault detection:
  - Force q_in stuck at 0 and issue set (10) → rsp_q=0, rsp_err=1.
  - Then issue toggle → expected value 1 (last_q=0), so rsp_err=1.
- Saturation:
  - Preload op_count to 16'hFFFE through 2 further commands → op_count reads 16'hFFFF and remains there.
